fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage plus IF/ID pipeline register for the pipelined 16-bit CPU; feeds the decode/regfile/ALU datapath directly downstream.
- Owns the PC and issues word addresses to a synchronous instruction memory with 1-cycle read latency.
- Absorbs a returning instruction in a 1-entry skid buffer while decode is stalled.
- Handles taken-branch redirect (PCSrc plus target from the branch adder) by flushing wrong-path instructions.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous
// instruction memory (slave) with 1-cycle read latency.
//   imem_addr : word address of the read (master -> slave)
//   imem_rd   : read strobe; data appears on imem_data the following cycle
//   imem_data : instruction returned for the previous cycle's read (slave -> master)
interface fetch_stage_if #(
  parameter int unsigned ISIZE = 16,
  parameter int unsigned DSIZE = 16
);
  logic [ISIZE-1:0] imem_addr;
  logic             imem_rd;
  logic [DSIZE-1:0] imem_data;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, issues reads to a 1-cycle-latency instruction memory, parks a
// returning instruction in a 1-entry skid buffer while decode is stalled, and
// flushes wrong-path instructions on a taken-branch redirect.
// Ports:
//   clk, rst            : clock; asynchronous active-high reset
//   stall               : hold IF/ID contents this cycle
//   redirect            : taken branch; overrides stall
//   redirect_pc         : branch target
//   imem                : instruction-memory bus (master side)
//   ifid_inst/pc/npc    : IF/ID instruction, its address, and address + 1
//   ifid_valid          : IF/ID holds a real instruction (0 = bubble)
module fetch_stage #(
  parameter int unsigned      ISIZE    = 16,
  parameter int unsigned      DSIZE    = 16,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [ISIZE-1:0] redirect_pc,
  fetch_stage_if.master    imem,
  output logic [DSIZE-1:0] ifid_inst,
  output logic [ISIZE-1:0] ifid_pc,
  output logic [ISIZE-1:0] ifid_npc,
  output logic             ifid_valid
);

  logic [ISIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [ISIZE-1:0] pend_pc_q, pend_pc_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DSIZE-1:0] skid_inst_q, skid_inst_d;
  logic [ISIZE-1:0] skid_pc_q, skid_pc_d;
  logic [DSIZE-1:0] ifid_inst_q, ifid_inst_d;
  logic [ISIZE-1:0] ifid_pc_q, ifid_pc_d;
  logic [ISIZE-1:0] ifid_npc_q, ifid_npc_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             issue;

  // While stalled, a new read may only go out if there is somewhere to put its
  // data next cycle: with a read in flight or the skid full, there is not.
  assign issue = !redirect && !(stall && (pend_valid_q || skid_valid_q));

  assign imem.imem_addr = fetch_pc_q;
  assign imem.imem_rd   = issue;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_npc_d   = ifid_npc_q;
    ifid_valid_d = ifid_valid_q;

    if (redirect) begin
      // Drop everything on the wrong path; returning imem_data is ignored.
      fetch_pc_d   = redirect_pc;
      pend_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ISIZE'(1);
        pend_pc_d  = fetch_pc_q;
      end
      pend_valid_d = issue;

      if (!stall) begin
        if (skid_valid_q) begin
          ifid_inst_d  = skid_inst_q;
          ifid_pc_d    = skid_pc_q;
          ifid_npc_d   = skid_pc_q + ISIZE'(1);
          ifid_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          ifid_inst_d  = imem.imem_data;
          ifid_pc_d    = pend_pc_q;
          ifid_npc_d   = pend_pc_q + ISIZE'(1);
          ifid_valid_d = pend_valid_q;
        end
      end else if (pend_valid_q) begin
        // IF/ID is frozen, so the arriving instruction parks in the skid.
        skid_inst_d  = imem.imem_data;
        skid_pc_d    = pend_pc_q;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      ifid_inst_q  <= '0;
      ifid_pc_q    <= '0;
      ifid_npc_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_npc_q   <= ifid_npc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign ifid_inst  = ifid_inst_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_npc   = ifid_npc_q;
  assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic [15:0] ifid_inst, ifid_pc, ifid_npc;
  logic        ifid_valid;
  logic [15:0] w_inst, w_pc, w_npc;
  logic        w_valid;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage_if #(.ISIZE(16), .DSIZE(16)) bus ();
  fetch_stage_if #(.ISIZE(16), .DSIZE(16)) wbus ();

  fetch_stage #(.ISIZE(16), .DSIZE(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .ifid_inst   (ifid_inst),
    .ifid_pc     (ifid_pc),
    .ifid_npc    (ifid_npc),
    .ifid_valid  (ifid_valid)
  );

  // Second instance exercises PC wrap from FFFE.
  fetch_stage #(.ISIZE(16), .DSIZE(16), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (wbus),
    .ifid_inst   (w_inst),
    .ifid_pc     (w_pc),
    .ifid_npc    (w_npc),
    .ifid_valid  (w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: imem[a] = A000 + a, 1-cycle latency.
  always @(posedge clk) begin
    bus.imem_data  <= bus.imem_rd  ? 16'hA000 + bus.imem_addr  : 16'hDEAD;
    wbus.imem_data <= wbus.imem_rd ? 16'hA000 + wbus.imem_addr : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Skid and in-flight read must never coexist.
  always @(negedge clk) begin
    if (!rst && dut.skid_valid_q && dut.pend_valid_q) begin
      n_fail++;
      $display("FAIL invariant: skid_valid=%b pend_valid=%b, expected not both 1",
               dut.skid_valid_q, dut.pend_valid_q);
    end
  end

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        exp_rd;     // imem_rd during the cycle
    logic [15:0] exp_addr;   // imem_addr during the cycle
    logic        exp_valid;  // ifid_valid after the edge
    logic [15:0] exp_pc;     // ifid_pc after the edge (when valid)
  } vec_t;

  vec_t vecs[19];

  // Drive one cycle's inputs at the negedge, check combinational outputs,
  // then check IF/ID just after the rising edge; returns at the next negedge.
  task automatic run_vec(input int i);
    logic [15:0] e_inst;
    logic [15:0] e_npc;
    stall       = vecs[i].stall;
    redirect    = vecs[i].redirect;
    redirect_pc = vecs[i].rpc;
    #1;
    chk($sformatf("v%0d imem_rd", i), 32'(bus.imem_rd), 32'(vecs[i].exp_rd));
    chk($sformatf("v%0d imem_addr", i), 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d ifid_valid", i), 32'(ifid_valid), 32'(vecs[i].exp_valid));
    if (vecs[i].exp_valid) begin
      e_inst = 16'hA000 + vecs[i].exp_pc;
      e_npc  = vecs[i].exp_pc + 16'h0001;
      chk($sformatf("v%0d ifid_pc", i), 32'(ifid_pc), 32'(vecs[i].exp_pc));
      chk($sformatf("v%0d ifid_inst", i), 32'(ifid_inst), 32'(e_inst));
      chk($sformatf("v%0d ifid_npc", i), 32'(ifid_npc), 32'(e_npc));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] p2;
    logic [15:0] p2_inst;
    logic [15:0] p2_npc;

    //           stall  redir  rpc       rd     addr      valid  pc
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0001};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0002};
    // 3-cycle stall holding 0002; 0003 parks in the skid
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0002};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0003};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0004};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0005};
    // redirect to 0040 while IF/ID holds 0005
    vecs[10] = '{1'b0, 1'b1, 16'h0040, 1'b0, 16'h0007, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b1, 16'h0040};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h0041};
    // fill the skid, then redirect+stall together, stall held one more cycle
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0043, 1'b1, 16'h0041};
    vecs[15] = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0043, 1'b0, 16'h0000};
    vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041, 1'b1, 16'h0040};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h0041};

    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("reset ifid_valid", 32'(ifid_valid), 32'h0);
    chk("reset ifid_pc", 32'(ifid_pc), 32'h0);
    chk("reset ifid_inst", 32'(ifid_inst), 32'h0);
    chk("reset ifid_npc", 32'(ifid_npc), 32'h0);
    chk("reset imem_addr", 32'(bus.imem_addr), 32'h0);
    chk("reset wrap imem_addr", 32'(wbus.imem_addr), 32'hFFFE);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(i);

    // Asynchronous reset between edges while streaming.
    stall    = 1'b0;
    redirect = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst ifid_valid", 32'(ifid_valid), 32'h0);
    chk("async rst ifid_pc", 32'(ifid_pc), 32'h0);
    chk("async rst imem_addr", 32'(bus.imem_addr), 32'h0);
    chk("async rst wrap ifid_valid", 32'(w_valid), 32'h0);
    chk("async rst wrap imem_addr", 32'(wbus.imem_addr), 32'hFFFE);
    @(negedge clk);
    rst = 1'b0;

    // Refetch from RESET_PC with the same timing; wrap instance streams FFFE, FFFF, 0000.
    for (int i = 0; i < 4; i++) begin
      run_vec(i);
      if (i == 0) begin
        chk("wrap v0 ifid_valid", 32'(w_valid), 32'h0);
      end else begin
        p2      = 16'hFFFD + 16'(i);
        p2_inst = 16'hA000 + p2;
        p2_npc  = p2 + 16'h0001;
        chk($sformatf("wrap v%0d ifid_valid", i), 32'(w_valid), 32'h1);
        chk($sformatf("wrap v%0d ifid_pc", i), 32'(w_pc), 32'(p2));
        chk($sformatf("wrap v%0d ifid_inst", i), 32'(w_inst), 32'(p2_inst));
        chk($sformatf("wrap v%0d ifid_npc", i), 32'(w_npc), 32'(p2_npc));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
